farbborg_frame_dma: RTL

Wishbone frame copier that sits directly upstream of the farbborg PWM slave. It is configured through a small Wishbone slave register file. It then masters the bus to read a frame of pixel words from system memory and write each word into the farbborg frame-buffer window. This lets the CPU update a full cube frame with one start command instead of 2048 stores.

---
 rtl/farbborg_frame_dma.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/farbborg_frame_dma.sv
// farbborg_frame_dma: Wishbone frame copier. It is configured through a slave
// register file (CTRL/STATUS/SRC/COUNT). It masters the bus to copy a frame
// from memory into the farbborg window.
// Ports: clk, reset (async, active-low), s_* config slave, m_* master, irq.
// Option FARBBORG_DMA_VSYNC_EN adds frame_sync and holds START until it pulses.
module farbborg_frame_dma #(
  parameter logic [31:0] DST_BASE  = 32'h8000_0000,
  parameter int          MAX_WORDS = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  output logic [31:0] s_dat_o,
  input  logic [3:0]  s_sel_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  output logic        s_ack_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  input  logic        m_ack_i,
`ifdef FARBBORG_DMA_VSYNC_EN
  input  logic        frame_sync,
`endif
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE, S_RD, S_WR, S_SYNC
  } state_t;

  localparam logic [11:0] MAXW = 12'(MAX_WORDS);

  state_t      state, state_n;
  logic [11:0] idx, idx_n, cnt, count;
  logic [31:0] src, rdata;
  logic [31:0] adr_n, dat_n;
  logic        cyc_n, stb_n, we_n;
  logic        done, abt, irq_en, abort_pend;
  logic        set_done, set_abt, go;
  logic        acc, wr, rd, ctrl_wr, stat_wr;
  logic        start_req, abort_req, busy;
  logic [11:0] cnt_clamp;
  logic [1:0]  ra;
  logic        unused;

  assign unused  = ^{s_sel_i, s_adr_i[31:4], s_adr_i[1:0],
                     m_dat_i[31:16]};
  assign m_sel_o = 4'hF;

  assign ra        = s_adr_i[3:2];
  assign acc       = s_cyc_i & s_stb_i & ~s_ack_o;
  assign wr        = acc & s_we_i;
  assign rd        = acc & ~s_we_i;
  assign ctrl_wr   = wr & (ra == 2'd0);
  assign stat_wr   = wr & (ra == 2'd1);
  // ABORT in the same write as START suppresses the START
  assign start_req = ctrl_wr & s_dat_i[0] & ~s_dat_i[1];
  assign abort_req = ctrl_wr & s_dat_i[1];
  assign busy      = (state != S_IDLE);
  assign cnt_clamp = (count > MAXW) ? MAXW : count;
  assign irq       = done & irq_en;

  always_comb begin
    unique case (ra)
      2'd0:    rdata = 32'h0;
      2'd1:    rdata = {28'h0, irq_en, abt, done, busy};
      2'd2:    rdata = src;
      default: rdata = {20'h0, count};
    endcase
  end

  // Bus outputs are registered; a cycle with stb low in RD/WR
  // is the gap where the next access is issued or an abort taken.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cyc_n    = m_cyc_o;
    stb_n    = m_stb_o;
    we_n     = m_we_o;
    adr_n    = m_adr_o;
    dat_n    = m_dat_o;
    set_done = 1'b0;
    set_abt  = 1'b0;
    go       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_req) begin
          if (cnt_clamp == 12'd0) begin
            set_done = 1'b1;
          end else begin
            go    = 1'b1;
            idx_n = 12'd0;
`ifdef FARBBORG_DMA_VSYNC_EN
            state_n = S_SYNC;
`else
            state_n = S_RD;
            cyc_n   = 1'b1;
            stb_n   = 1'b1;
            we_n    = 1'b0;
            adr_n   = src;
`endif
          end
        end
      end
      S_RD: begin
        if (m_stb_o) begin
          if (m_ack_i) begin
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            dat_n   = {16'h0, m_dat_i[15:0]};
            state_n = S_WR;
          end
        end else if (abort_pend) begin
          state_n = S_IDLE;
          set_abt = 1'b1;
        end else begin
          cyc_n = 1'b1;
          stb_n = 1'b1;
          we_n  = 1'b0;
          adr_n = src + {18'h0, idx, 2'b00};
        end
      end
      S_WR: begin
        if (m_stb_o) begin
          if (m_ack_i) begin
            cyc_n = 1'b0;
            stb_n = 1'b0;
            we_n  = 1'b0;
            idx_n = idx + 12'd1;
            if (idx + 12'd1 == cnt) begin
              state_n  = S_IDLE;
              set_done = 1'b1;
            end else if (abort_pend) begin
              state_n = S_IDLE;
              set_abt = 1'b1;
            end else begin
              state_n = S_RD;
            end
          end
        end else if (abort_pend) begin
          state_n = S_IDLE;
          set_abt = 1'b1;
        end else begin
          cyc_n = 1'b1;
          stb_n = 1'b1;
          we_n  = 1'b1;
          adr_n = DST_BASE + {18'h0, idx, 2'b00};
        end
      end
      S_SYNC: begin
        if (abort_pend) begin
          state_n = S_IDLE;
          set_abt = 1'b1;
`ifdef FARBBORG_DMA_VSYNC_EN
        end else if (frame_sync) begin
          state_n = S_RD;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          we_n    = 1'b0;
          adr_n   = src;
`endif
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx        <= 12'd0;
      cnt        <= 12'd0;
      count      <= 12'd0;
      src        <= 32'h0;
      m_cyc_o    <= 1'b0;
      m_stb_o    <= 1'b0;
      m_we_o     <= 1'b0;
      m_adr_o    <= 32'h0;
      m_dat_o    <= 32'h0;
      s_ack_o    <= 1'b0;
      s_dat_o    <= 32'h0;
      done       <= 1'b0;
      abt        <= 1'b0;
      irq_en     <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      m_cyc_o <= cyc_n;
      m_stb_o <= stb_n;
      m_we_o  <= we_n;
      m_adr_o <= adr_n;
      m_dat_o <= dat_n;
      s_ack_o <= acc;
      s_dat_o <= rd ? rdata : 32'h0;
      if (wr && ra == 2'd2 && !busy) src <= {s_dat_i[31:2], 2'b00};
      if (wr && ra == 2'd3 && !busy) count <= s_dat_i[11:0];
      if (ctrl_wr) irq_en <= s_dat_i[2];
      if (go) begin
        cnt  <= cnt_clamp;
        done <= 1'b0;
        abt  <= 1'b0;
      end else begin
        if (set_done) done <= 1'b1;
        else if (stat_wr && s_dat_i[1]) done <= 1'b0;
        if (set_abt) begin
          abt  <= 1'b1;
          done <= 1'b0;
        end else if (stat_wr && s_dat_i[2]) begin
          abt <= 1'b0;
        end
      end
      if (state_n == S_IDLE) abort_pend <= 1'b0;
      else if (abort_req && busy) abort_pend <= 1'b1;
    end
  end

endmodule
